// File: rtl/instruction_fetch.sv
// Instruction fetch: owns fetch_pc, reads the async ROM, and queues {pc, instr} for decode. Optional: FETCH_MISALIGN_TRAP_EN.
// Latency: an instruction reaches the head one cycle after its address is presented; a redirect target arrives two cycles after the redirect.
// Backpressure: a full FIFO without a pop holds fetch_pc; redirect flushes the FIFO and restarts fetch.
package riscv_pkg;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int INSTRUCTION_BYTES = 4;
endpackage

module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [XLEN-1:0]              imem_address,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [XLEN-1:0]              out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                         fetch_misaligned
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]              pc;
    logic [INSTRUCTION_WIDTH-1:0] instr;
  } entry_t;

  entry_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [XLEN-1:0]    fetch_pc;
  logic [XLEN-1:0]    redirect_target;
  logic [XLEN-1:0]    aligned_target;
  logic               fetch_en;
  logic               push;
  logic               pop;

  assign aligned_target = redirect_pc & ~XLEN'(INSTRUCTION_BYTES - 1);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;
  logic redirect_misaligned;

  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redirect_target     = redirect_misaligned ? redirect_pc : aligned_target;
  assign fetch_en            = !misaligned_q;
  assign fetch_misaligned    = misaligned_q;

  // Sticky until the next redirect; an aligned target clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else if (redirect_valid) begin
      misaligned_q <= redirect_misaligned;
    end
  end
`else
  assign redirect_target = aligned_target;
  assign fetch_en        = 1'b1;
`endif

  assign imem_address    = fetch_pc;
  assign out_valid       = (count != '0);
  assign out_pc          = fifo_mem[rd_ptr].pc;
  assign out_instruction = fifo_mem[rd_ptr].instr;
  assign pop             = out_valid & out_ready;
  // Full FIFO with a pop still pushes: the slot under rd_ptr is read this cycle and overwritten at the edge.
  assign push            = !redirect_valid & fetch_en & ((count < CNT_W'(FIFO_DEPTH)) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_VECTOR;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_instruction};
        wr_ptr           <= wr_ptr + PTR_W'(1);
        fetch_pc         <= fetch_pc + XLEN'(INSTRUCTION_BYTES);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Requester side of the instruction ROM interface.
- Owns the fetch PC and drives a word-aligned byte address to the asynchronous-read instruction ROM.
- Captures the returned instruction together with its PC into a small prefetch FIFO, and hands entries to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute; a redirect flushes the FIFO and restarts fetch.

Parameters:
- XLEN, 32, address/PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC loaded at reset; must be a multiple of INSTRUCTION_BYTES.
- FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset.
- imem_address  out  XLEN  byte address to ROM; equals fetch_pc.
- imem_instruction  in  INSTRUCTION_WIDTH  ROM read data, valid in the same cycle as imem_address.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instruction  out  INSTRUCTION_WIDTH  head instruction.
- out_pc  out  XLEN  PC of the head instruction.

Interface (already decided): one clock; reset is asynchronous and active-low. rst_n low immediately clears all state, with no clock edge needed.

Behaviour:
- Reset values:
  - fetch_pc = RESET_VECTOR.
  - FIFO count = 0, read/write pointers = 0.
  - out_valid = 0; out_instruction and out_pc = 0.
- imem_address = fetch_pc combinationally. INSTRUCTION_WIDTH and INSTRUCTION_BYTES come from riscv_pkg.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < FIFO_DEPTH | pop).
  - Full FIFO with a simultaneous pop still pushes, giving full throughput.
- On push:
  - The entry {fetch_pc, imem_instruction} is written at the write pointer.
  - fetch_pc <= fetch_pc + INSTRUCTION_BYTES, modulo 2^XLEN (wraps from 0xFFFF_FFFC to 0).
- On pop: the read pointer advances.
- count update: +1 on push only, -1 on pop only, unchanged when both occur.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Full FIFO, no pop: no push, fetch_pc holds, and the ROM address is re-presented unchanged.
- Empty FIFO: out_valid = 0, and out_ready is ignored.
- Latency: an instruction presented at cycle N appears at the head (out_valid = 1) in cycle N+1 at the earliest. After rst_n deasserts, the first instruction (at RESET_VECTOR) is valid on the 2nd rising edge's output.
- Redirect has priority over push and pop:
  - count <= 0 and both pointers <= 0.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Any pop that cycle is dropped: out_valid may be 1 during the redirect cycle, but decode must treat that head as squashed. Decode owns the squash; this block still shows the head that cycle.
  - The next cycle has out_valid = 0. The target instruction is valid in the cycle after that.
- Back-to-back redirects: the last one wins, and no entries are pushed in between.
- out_instruction and out_pc are driven from the FIFO head. Contents are don't-care when out_valid = 0, but must be 0 from reset until the first push.
- Redirect asserted during reset: ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output fetch_misaligned, 1 bit, reset 0.
  - A redirect with redirect_pc[1:0] != 0 sets fetch_misaligned (sticky), loads fetch_pc = redirect_pc unmodified, flushes the FIFO and inhibits all pushes.
  - The next redirect with an aligned target clears the flag and resumes fetch.
- When undefined:
  - No port.
  - Low two bits are silently forced to 0, as described above.

Test Plan:
- Reset release, out_ready = 1, ROM holding word i = 0x1000_0000 + i → imem_address goes 0x0, 0x4, 0x8… one per cycle; out_pc/out_instruction pairs are (0x0, 0x1000_0000), (0x4, 0x1000_0001)…, one per cycle with no bubbles.
- out_ready = 0 for 10 cycles → count saturates at 4 (0x0–0xC buffered), imem_address holds 0x10. Raise out_ready → pops in order 0x0, 0x4, 0x8, 0xC, 0x10 with no gap or duplicate.
- Full FIFO, then a single out_ready pulse → exactly one pop and one push that cycle; count stays 4; fetch_pc advances by 4.
- Redirect to 0x200 while holding 3 entries → next cycle out_valid = 0 and imem_address = 0x200. The following cycle out_pc = 0x200; old entries are never delivered.
- Redirect to 0x203 (macro off) → fetch resumes at 0x200. With the macro on: fetch_misaligned = 1, out_valid stays 0; a later redirect to 0x300 clears the flag and delivers 0x300.
- RESET_VECTOR = 0xFFFF_FFF8 → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap). rst_n asserted mid-stream → out_valid drops asynchronously and fetch restarts at RESET_VECTOR.
